// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and forwarding-source indices for the ID-stage register file scoreboard.
package regfile_scoreboard_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Forwarding sources ordered youngest first; lower index wins on a match.
    localparam int unsigned FWD_EX  = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = 2;

endpackage

// File: rtl/sb_read_port.sv
// One read port: zero register, clean-register read, then youngest-first forwarding mux.
module sb_read_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NFWD   = 3
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   cnt_zero_i,
    input  logic [DATA_W-1:0]      arr_data_i,
    input  logic [NFWD-1:0]        fwd_valid_i,
    input  logic [NFWD*ADDR_W-1:0] fwd_waddr_i,
    input  logic [NFWD-1:0]        fwd_data_ok_i,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   ready_o
);

    logic hit;

    always_comb begin
        data_o  = arr_data_i;
        ready_o = 1'b0;
        hit     = 1'b0;
        if (addr_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
        end else if (cnt_zero_i) begin
            ready_o = 1'b1;
        end else begin
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && fwd_valid_i[k] && fwd_waddr_i[k*ADDR_W +: ADDR_W] == addr_i) begin
                    hit = 1'b1;
                    if (fwd_data_ok_i[k]) begin
                        data_o  = fwd_wdata_i[k*DATA_W +: DATA_W];
                        ready_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters, forwarding and decode interlock.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NFWD   = 3,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_ready,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_waddr,
    output logic                   issue_fire,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NFWD-1:0]        fwd_data_ok,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic                   wb_we,
    input  logic [ADDR_W-1:0]      wb_waddr,
    input  logic [DATA_W-1:0]      wb_wdata,
    input  logic                   flush,
    output logic                   stallreq
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              sat_stall;
    logic              rd_stall;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              cnt_zero;
        logic [DATA_W-1:0] arr_data;

        assign addr     = rd_addr[i*ADDR_W +: ADDR_W];
        assign cnt_zero = (cnt_q[addr] == '0);
        // A commit landing this cycle is visible to a clean-register read.
        assign arr_data = (wb_we && wb_waddr == addr) ? wb_wdata : mem_q[addr];

        sb_read_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .NFWD  (NFWD)
        ) u_port (
            .addr_i       (addr),
            .cnt_zero_i   (cnt_zero),
            .arr_data_i   (arr_data),
            .fwd_valid_i  (fwd_valid),
            .fwd_waddr_i  (fwd_waddr),
            .fwd_data_ok_i(fwd_data_ok),
            .fwd_wdata_i  (fwd_wdata),
            .data_o       (rd_data[i*DATA_W +: DATA_W]),
            .ready_o      (rd_ready[i])
        );
    end

    always_comb begin
        rd_stall  = |(rd_en & ~rd_ready);
        sat_stall = issue_valid && issue_waddr != '0 && cnt_q[issue_waddr] == '1;
        stallreq  = rd_stall | sat_stall;
        issue_fire = issue_valid & ~stallreq;
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            mem_d[r] = mem_q[r];
            cnt_d[r] = cnt_q[r];
            inc = issue_fire && issue_waddr == ADDR_W'(r);
            dec = wb_we && wb_waddr == ADDR_W'(r);
            if (r != 0) begin
                if (dec) mem_d[r] = wb_wdata;
                if (flush) begin
                    cnt_d[r] = '0;
                end else if (inc && !dec) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end else if (dec && !inc && cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= mem_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned NFWD   = 3;
    localparam int unsigned CNT_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NRD-1:0]         rd_en;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD*DATA_W-1:0]  rd_data;
    logic [NRD-1:0]         rd_ready;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_waddr;
    logic                   issue_fire;
    logic [NFWD-1:0]        fwd_valid;
    logic [NFWD*ADDR_W-1:0] fwd_waddr;
    logic [NFWD-1:0]        fwd_data_ok;
    logic [NFWD*DATA_W-1:0] fwd_wdata;
    logic                   wb_we;
    logic [ADDR_W-1:0]      wb_waddr;
    logic [DATA_W-1:0]      wb_wdata;
    logic                   flush;
    logic                   stallreq;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NRD   (NRD),
        .NFWD  (NFWD),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .issue_valid(issue_valid),
        .issue_waddr(issue_waddr),
        .issue_fire (issue_fire),
        .fwd_valid  (fwd_valid),
        .fwd_waddr  (fwd_waddr),
        .fwd_data_ok(fwd_data_ok),
        .fwd_wdata  (fwd_wdata),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .flush      (flush),
        .stallreq   (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en       = '0;
        rd_addr     = '0;
        issue_valid = 1'b0;
        issue_waddr = '0;
        fwd_valid   = '0;
        fwd_waddr   = '0;
        fwd_data_ok = '0;
        fwd_wdata   = '0;
        wb_we       = 1'b0;
        wb_waddr    = '0;
        wb_wdata    = '0;
        flush       = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [NRD-1:0] en);
        rd_addr = {a1, a0};
        rd_en   = en;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic [ADDR_W-1:0] a,
                           input logic ok, input logic [DATA_W-1:0] d);
        fwd_valid[k]                   = v;
        fwd_waddr[k*ADDR_W +: ADDR_W]  = a;
        fwd_data_ok[k]                 = ok;
        fwd_wdata[k*DATA_W +: DATA_W]  = d;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        issue_valid = 1'b1;
        issue_waddr = a;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        tick();
        wb_we    = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        rd(5'd3, 5'd5, 2'b11);
        #2;
        check("reset_data", 64'(rd_data), 64'h0);
        check("reset_ready", 64'(rd_ready), 64'h3);
        check("reset_stall", 64'(stallreq), 64'h0);
        check("reset_fire", 64'(issue_fire), 64'h0);
        #10;
        rst = 1'b1;
        tick();

        // Build state, then assert reset away from a clock edge.
        idle();
        commit(5'd5, 32'h55);
        issue(5'd3);
        rd(5'd3, 5'd5, 2'b11);
        #1;
        check("pre_rst_r3_ready", 64'(rd_ready), 64'h2);
        check("pre_rst_r5_data", 64'(rd_data[63:32]), 64'h55);
        check("pre_rst_stall", 64'(stallreq), 64'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_data", 64'(rd_data), 64'h0);
        check("mid_rst_ready", 64'(rd_ready), 64'h3);
        check("mid_rst_stall", 64'(stallreq), 64'h0);
        #3;
        rst = 1'b1;
        tick();

        // Forward priority on r8 with counter 2.
        idle();
        issue(5'd8);
        issue(5'd8);
        set_fwd(0, 1'b1, 5'd8, 1'b1, 32'hAAAA0000);
        set_fwd(1, 1'b1, 5'd8, 1'b1, 32'hBBBB1111);
        set_fwd(2, 1'b1, 5'd8, 1'b1, 32'hCCCC2222);
        rd(5'd8, 5'd0, 2'b01);
        #1;
        check("fwd_ex_data", 64'(rd_data[31:0]), 64'hAAAA0000);
        check("fwd_ex_ready", 64'(rd_ready[0]), 64'h1);
        check("fwd_ex_stall", 64'(stallreq), 64'h0);
        fwd_valid = 3'b110;
        rd(5'd8, 5'd8, 2'b11);
        #1;
        check("fwd_mem_data_p0", 64'(rd_data[31:0]), 64'hBBBB1111);
        check("fwd_mem_data_p1", 64'(rd_data[63:32]), 64'hBBBB1111);
        fwd_valid = 3'b100;
        #1;
        check("fwd_wb_data", 64'(rd_data[31:0]), 64'hCCCC2222);
        fwd_valid   = 3'b110;
        fwd_data_ok = 3'b101;
        #1;
        check("fwd_mem_notok_ready", 64'(rd_ready), 64'h0);
        check("fwd_mem_notok_stall", 64'(stallreq), 64'h1);
        fwd_valid = 3'b000;
        #1;
        check("fwd_nomatch_ready", 64'(rd_ready), 64'h0);

        // Load-use: stall one cycle, then forward from MEM.
        idle();
        issue(5'd9);
        set_fwd(0, 1'b1, 5'd9, 1'b0, 32'h0);
        rd(5'd9, 5'd0, 2'b01);
        issue_valid = 1'b1;
        issue_waddr = 5'd10;
        #1;
        check("lu_stall", 64'(stallreq), 64'h1);
        check("lu_ready", 64'(rd_ready[0]), 64'h0);
        check("lu_fire_blocked", 64'(issue_fire), 64'h0);
        tick();
        set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0);
        set_fwd(1, 1'b1, 5'd9, 1'b1, 32'h1234);
        #1;
        check("lu_mem_data", 64'(rd_data[31:0]), 64'h1234);
        check("lu_mem_stall", 64'(stallreq), 64'h0);
        check("lu_mem_fire", 64'(issue_fire), 64'h1);
        tick();
        idle();
        rd(5'd10, 5'd0, 2'b01);
        #1;
        check("lu_r10_pending", 64'(rd_ready[0]), 64'h0);

        // Commit of r4 with same-cycle read, then counter behaviour.
        idle();
        issue(5'd4);
        wb_we    = 1'b1;
        wb_waddr = 5'd4;
        wb_wdata = 32'hDEAD;
        set_fwd(2, 1'b1, 5'd4, 1'b1, 32'hDEAD);
        rd(5'd4, 5'd0, 2'b01);
        #1;
        check("wb_same_cycle_data", 64'(rd_data[31:0]), 64'hDEAD);
        check("wb_same_cycle_ready", 64'(rd_ready[0]), 64'h1);
        tick();
        idle();
        rd(5'd4, 5'd0, 2'b01);
        #1;
        check("wb_after_data", 64'(rd_data[31:0]), 64'hDEAD);
        check("wb_after_ready", 64'(rd_ready[0]), 64'h1);
        wb_we    = 1'b1;
        wb_waddr = 5'd4;
        wb_wdata = 32'hBEEF;
        #1;
        check("wb_bypass_data", 64'(rd_data[31:0]), 64'hBEEF);
        tick();
        idle();
        issue(5'd4);
        issue_valid = 1'b1;
        issue_waddr = 5'd4;
        wb_we       = 1'b1;
        wb_waddr    = 5'd4;
        wb_wdata    = 32'h1111;
        #1;
        check("simul_fire", 64'(issue_fire), 64'h1);
        tick();
        idle();
        rd(5'd4, 5'd0, 2'b01);
        #1;
        check("simul_cnt_held", 64'(rd_ready[0]), 64'h0);
        wb_we    = 1'b1;
        wb_waddr = 5'd4;
        wb_wdata = 32'h2222;
        tick();
        idle();
        rd(5'd4, 5'd0, 2'b01);
        #1;
        check("simul_then_commit", 64'(rd_data[31:0]), 64'h2222);

        // Saturation on r7.
        idle();
        issue(5'd7);
        issue(5'd7);
        issue(5'd7);
        issue_valid = 1'b1;
        issue_waddr = 5'd7;
        #1;
        check("sat_stall", 64'(stallreq), 64'h1);
        check("sat_fire", 64'(issue_fire), 64'h0);
        tick();
        idle();
        commit(5'd7, 32'h70);
        commit(5'd7, 32'h71);
        rd(5'd7, 5'd0, 2'b01);
        #1;
        check("sat_cnt_one_left", 64'(rd_ready[0]), 64'h0);
        commit(5'd7, 32'h72);
        #1;
        check("sat_drained_data", 64'(rd_data[31:0]), 64'h72);
        check("sat_drained_ready", 64'(rd_ready[0]), 64'h1);

        // Flush with commit and issue in the same cycle.
        idle();
        flush       = 1'b1;
        wb_we       = 1'b1;
        wb_waddr    = 5'd2;
        wb_wdata    = 32'h5;
        issue_valid = 1'b1;
        issue_waddr = 5'd11;
        tick();
        idle();
        rd(5'd2, 5'd8, 2'b11);
        #1;
        check("flush_r2_data", 64'(rd_data[31:0]), 64'h5);
        check("flush_ready", 64'(rd_ready), 64'h3);
        check("flush_stall", 64'(stallreq), 64'h0);
        rd(5'd11, 5'd10, 2'b11);
        #1;
        check("flush_issue_ignored", 64'(rd_ready), 64'h3);

        // r0 is never written and never pending.
        idle();
        issue_valid = 1'b1;
        issue_waddr = 5'd0;
        wb_we       = 1'b1;
        wb_waddr    = 5'd0;
        wb_wdata    = 32'hFF;
        rd(5'd0, 5'd0, 2'b11);
        #1;
        check("r0_same_cycle_data", 64'(rd_data), 64'h0);
        check("r0_issue_fire", 64'(issue_fire), 64'h1);
        tick();
        idle();
        rd(5'd0, 5'd0, 2'b11);
        #1;
        check("r0_data", 64'(rd_data), 64'h0);
        check("r0_ready", 64'(rd_ready), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the ID stage. It adds per-register pending-write counters, N-source forwarding and a decode interlock (stall request).
- Serves NRD combinational read ports and one write-back port.
- Tracks every in-flight destination register from issue to commit.
- Returns forwarded data when an older in-flight producer can supply it, and raises `stallreq` when it cannot (load-use, or a producer not yet in a forwarding stage).

## Interface
Parameters:
- DATA_W, 32: register width.
- ADDR_W, 5: register address width; 2**ADDR_W registers, register 0 hard-wired to zero.
- NRD, 2: number of read ports.
- NFWD, 3: number of forwarding sources. Index 0 is the youngest stage (EX), then MEM, then WB.
- CNT_W, 2: width of each pending-write counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous and active-low (asserted when 0).
- rd_en  in  NRD  read port i is used by the decoding instruction.
- rd_addr  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data per port.
- rd_ready  out  NRD  rd_data of port i is valid this cycle.
- issue_valid  in  1  decoding instruction writes a register.
- issue_waddr  in  ADDR_W  its destination.
- issue_fire  out  1  issue accepted this cycle (= issue_valid & ~stallreq).
- fwd_valid  in  NFWD  source k holds a register-writing instruction.
- fwd_waddr  in  NFWD*ADDR_W  destination of source k.
- fwd_data_ok  in  NFWD  source k's result is computed; 0 for a load still in EX.
- fwd_wdata  in  NFWD*DATA_W  result of source k.
- wb_we, wb_waddr, wb_wdata  in  1, ADDR_W, DATA_W  commit write.
- flush  in  1  pipeline-wide discard of all uncommitted instructions.
- stallreq  out  1  decode must hold.

## Operation
- **Storage:** 2**ADDR_W x DATA_W array plus 2**ADDR_W counters of CNT_W bits. Entry 0 is never written and its counter stays 0.
- **Issue:** on issue_fire with issue_waddr != 0, counter[issue_waddr] increments.
- **Commit:** on wb_we with wb_waddr != 0, the array is written and counter[wb_waddr] decrements. If the counter is already 0 it stays 0.
- **Simultaneous issue and commit** to the same register: the counter is unchanged.
- **Flush:** all counters are cleared to 0. A commit in the same cycle still writes the array. Issue in the same cycle is ignored.
- **Read resolution, port i, first match wins:**
  - addr == 0 → data 0, ready.
  - counter == 0 → array data, ready. If wb_we hits the same address in this cycle, wb_wdata is bypassed instead.
  - Otherwise, find the lowest k with fwd_valid[k] and fwd_waddr[k] == addr:
    - if fwd_data_ok[k] = 1 → data is fwd_wdata[k], ready;
    - if fwd_data_ok[k] = 0 → not ready.
  - No match → not ready. rd_data is then the array value and is don't-care for checking.
- **Stall:** stallreq = OR over i of (rd_en[i] & ~rd_ready[i]), OR (issue_valid & issue_waddr != 0 & counter[issue_waddr] == all-ones). Saturated counters block issue; they never wrap.

## Timing
- Reads, rd_ready and stallreq are fully combinational from the inputs and the current state.
- Counter and array updates take effect at the next rising clk edge.
- Reset, asynchronous on rst = 0: all counters reset to 0 and all array entries to 0. rd_data follows these values combinationally, so every enabled port reads 0 and is ready. stallreq = 0 and issue_fire = 0 with no issue_valid.
- Reset asserted mid-operation discards all pending state immediately.
- Load-use behaviour: with a load in EX (k=0, data_ok=0), the consumer stalls for one cycle. The next cycle it forwards from MEM (k=1).

## Structure
- Shared package: the ADDR_W/DATA_W defaults, and the forward-source index constants FWD_EX=0, FWD_MEM=1, FWD_WB=2.
- One sub-module, `sb_read_port`: the priority forward mux plus ready logic, instantiated NRD times with a generate loop.
- The top level holds the array, the counters and the stall OR.

## Test plan
- **Reset:** hold rst=0 with rd_addr={5,3}, rd_en=11 → rd_data={0,0}, rd_ready=11, stallreq=0.
- **Forward priority:**
  - Setup: issue r8 twice (counter=2). fwd_valid=111, all fwd_waddr=8, data_ok=111, fwd_wdata={A,B,C} for k={0,1,2}.
  - Result: read of r8 returns A (EX). With EX invalid it returns B.
- **Load-use:**
  - Setup: counter[9]=1, fwd_valid[0]=1, fwd_waddr[0]=9, data_ok[0]=0, read r9 → stallreq=1.
  - Next cycle: the load moves to MEM with data_ok=1 and wdata=0x1234 → read returns 0x1234, stallreq=0.
- **WB bypass and counters:**
  - Issue r4 (counter 1). Commit r4=0xDEAD while reading r4 → same-cycle read returns 0xDEAD.
  - Next cycle: counter 0, array 0xDEAD.
  - Simultaneous issue and commit of r4 → counter stays 1.
- **Saturation:** CNT_W=2, issue r7 three times → counter 3. A 4th issue_valid to r7 gives stallreq=1, issue_fire=0, counter stays 3.
- **Flush and r0:**
  - flush with counters nonzero and commit of r2=5 in the same cycle → all counters 0, r2 reads 5.
  - Writes and issues to r0 → r0 always reads 0 and ready.
